// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - pipeline state codes, default widths and update entry type for the DDS voice bank
// DDS_PHASE_RESET_EN adds the phase-reset flag to the update entry.
package dds_pkg;

   localparam logic [1:0] ST_READ   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;
   localparam logic [1:0] ST_IDLE   = 2'd3;

   localparam int DEF_VOICES     = 256;
   localparam int DEF_ADDR_W     = 8;
   localparam int DEF_PHASE_W    = 32;
   localparam int DEF_OUT_W      = 10;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef struct packed {
`ifdef DDS_PHASE_RESET_EN
      logic                   phase_rst;
`endif
      logic [DEF_ADDR_W-1:0]  voice;
      logic [DEF_PHASE_W-1:0] delta;
   } upd_entry_t;

endpackage

// File: rtl/dds_update_fifo.sv
// rtl/dds_update_fifo.sv - synchronous ready/valid update FIFO with full/empty flags
module dds_update_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_data  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = i_push && !o_full;
      do_pop   = i_pop && !o_empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end

endmodule

// File: rtl/dds_voice_bank.sv
// rtl/dds_voice_bank.sv - multi-voice DDS phase accumulator bank with buffered tuning updates
// DDS_PHASE_RESET_EN: UPDATE entries flagged phase_rst also zero the voice phase.
module dds_voice_bank
   import dds_pkg::*;
#(
   parameter int VOICES     = DEF_VOICES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int PHASE_W    = DEF_PHASE_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_upd_valid,
   output logic               o_upd_ready,
   input  logic [ADDR_W-1:0]  i_upd_voice,
   input  logic [PHASE_W-1:0] i_upd_delta,
   input  logic               i_upd_phase_rst,
   input  logic [ADDR_W-1:0]  i_voice_index,
   input  logic [1:0]         i_pipeline_state,
   output logic [OUT_W-1:0]   o_phase,
   output logic               o_phase_valid,
   output logic               o_wrap,
   output logic [ADDR_W-1:0]  o_voice_index_next,
   output logic               o_init_done
);
`ifdef DDS_PHASE_RESET_EN
   localparam int ENTRY_W = PHASE_W + ADDR_W + 1;
`else
   localparam int ENTRY_W = PHASE_W + ADDR_W;
`endif
   localparam logic [ADDR_W:0] VOICES_L = (ADDR_W+1)'(VOICES);

   logic [PHASE_W-1:0] phase_mem [VOICES];
   logic [PHASE_W-1:0] delta_mem [VOICES];
   logic [PHASE_W-1:0] phase_rd_q, delta_rd_q;

   logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
   logic               init_done_q, init_done_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [OUT_W-1:0]   phase_out_q, phase_out_d;
   logic               wrap_q, wrap_d, valid_q, valid_d;

   logic [PHASE_W:0]   sum;
   logic               addr_ok, upd_ok, rd_en;
   logic               ph_we, dl_we;
   logic [ADDR_W-1:0]  ph_waddr, dl_waddr;
   logic [PHASE_W-1:0] ph_wdata, dl_wdata;

   logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
   logic [ADDR_W-1:0]  upd_voice;
   logic [PHASE_W-1:0] upd_delta;

`ifdef DDS_PHASE_RESET_EN
   logic upd_phase_rst;
   assign fifo_wdata    = {i_upd_phase_rst, i_upd_voice, i_upd_delta};
   assign upd_phase_rst = fifo_rdata[ENTRY_W-1];
`else
   logic unused_phase_rst;
   assign unused_phase_rst = i_upd_phase_rst;
   assign fifo_wdata       = {i_upd_voice, i_upd_delta};
`endif
   assign upd_voice = fifo_rdata[PHASE_W +: ADDR_W];
   assign upd_delta = fifo_rdata[PHASE_W-1:0];

   assign o_upd_ready        = !fifo_full && init_done_q;
   assign fifo_push          = i_upd_valid && o_upd_ready;
   assign o_phase            = phase_out_q;
   assign o_phase_valid      = valid_q;
   assign o_wrap             = wrap_q;
   assign o_voice_index_next = addr_q;
   assign o_init_done        = init_done_q;

   dds_update_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (fifo_push),
      .i_data  (fifo_wdata),
      .i_pop   (fifo_pop),
      .o_data  (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   always_comb begin
      addr_ok     = ({1'b0, addr_q} < VOICES_L);
      upd_ok      = ({1'b0, upd_voice} < VOICES_L);
      sum         = {1'b0, phase_rd_q} + {1'b0, delta_rd_q};
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
      addr_d      = addr_q;
      phase_out_d = phase_out_q;
      wrap_d      = wrap_q;
      valid_d     = 1'b0;
      rd_en       = 1'b0;
      fifo_pop    = 1'b0;
      ph_we       = 1'b0;
      ph_waddr    = addr_q;
      ph_wdata    = sum[PHASE_W-1:0];
      dl_we       = 1'b0;
      dl_waddr    = upd_voice;
      dl_wdata    = upd_delta;
      if (!init_done_q) begin
         // Clear sweep owns both arrays; the pipeline is ignored until it ends.
         ph_we       = 1'b1;
         ph_waddr    = clr_cnt_q[ADDR_W-1:0];
         ph_wdata    = '0;
         dl_we       = 1'b1;
         dl_waddr    = clr_cnt_q[ADDR_W-1:0];
         dl_wdata    = '0;
         clr_cnt_d   = clr_cnt_q + 1'b1;
         init_done_d = (clr_cnt_q == VOICES_L - 1'b1);
      end else begin
         case (i_pipeline_state)
            ST_READ: begin
               addr_d = i_voice_index;
               rd_en  = 1'b1;
            end
            ST_ACCUM: begin
               if (addr_ok) begin
                  ph_we       = 1'b1;
                  phase_out_d = sum[PHASE_W-1 -: OUT_W];
                  wrap_d      = sum[PHASE_W];
                  valid_d     = 1'b1;
               end
            end
            ST_UPDATE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  if (upd_ok) begin
                     dl_we = 1'b1;
`ifdef DDS_PHASE_RESET_EN
                     if (upd_phase_rst) begin
                        ph_we    = 1'b1;
                        ph_waddr = upd_voice;
                        ph_wdata = '0;
                     end
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
         addr_q      <= '0;
         phase_out_q <= '0;
         wrap_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= init_done_d;
         addr_q      <= addr_d;
         phase_out_q <= phase_out_d;
         wrap_q      <= wrap_d;
         valid_q     <= valid_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (ph_we) phase_mem[ph_waddr] <= ph_wdata;
      if (dl_we) delta_mem[dl_waddr] <= dl_wdata;
      if (rd_en) begin
         phase_rd_q <= phase_mem[i_voice_index];
         delta_rd_q <= delta_mem[i_voice_index];
      end
   end

endmodule

// File: tb/tb_dds_voice_bank.sv
// tb/tb_dds_voice_bank.sv - self-checking bench for dds_voice_bank (256-voice and 200-voice instances)
module tb_dds_voice_bank;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, upd_valid, upd_phase_rst;
   logic [7:0]  upd_voice, voice_index;
   logic [31:0] upd_delta;
   logic [1:0]  pstate;

   logic        a_ready, a_valid, a_wrap, a_init;
   logic        b_ready, b_valid, b_wrap, b_init;
   logic [9:0]  a_phase, b_phase;
   logic [7:0]  a_vin, b_vin;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   dds_voice_bank dut_a (
      .i_clk(clk), .i_reset(rst), .i_upd_valid(upd_valid), .o_upd_ready(a_ready),
      .i_upd_voice(upd_voice), .i_upd_delta(upd_delta), .i_upd_phase_rst(upd_phase_rst),
      .i_voice_index(voice_index), .i_pipeline_state(pstate), .o_phase(a_phase),
      .o_phase_valid(a_valid), .o_wrap(a_wrap), .o_voice_index_next(a_vin), .o_init_done(a_init)
   );

   dds_voice_bank #(.VOICES(200)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_upd_valid(upd_valid), .o_upd_ready(b_ready),
      .i_upd_voice(upd_voice), .i_upd_delta(upd_delta), .i_upd_phase_rst(upd_phase_rst),
      .i_voice_index(voice_index), .i_pipeline_state(pstate), .o_phase(b_phase),
      .o_phase_valid(b_valid), .o_wrap(b_wrap), .o_voice_index_next(b_vin), .o_init_done(b_init)
   );

   // Behavioural model, one slot per instance: [0] = 256 voices, [1] = 200 voices.
   logic [31:0] mph [2][256];
   logic [31:0] mdl [2][256];
   logic [40:0] mfifo [2][4];
   int          mcnt [2];
   int          mcyc [2];
   bit          m_init [2];
   bit          m_valid [2];
   bit          m_wrap [2];
   logic [9:0]  m_phase [2];
   logic [7:0]  m_lat [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int          vmax;
         bit          do_push;
         logic [32:0] s;
         logic [40:0] e;
         vmax = (k == 0) ? 256 : 200;
         if (rst) begin
            for (int v = 0; v < 256; v++) begin
               mph[k][v] = '0;
               mdl[k][v] = '0;
            end
            mcnt[k] = 0; mcyc[k] = 0; m_init[k] = 0;
            m_valid[k] = 0; m_wrap[k] = 0; m_phase[k] = '0; m_lat[k] = '0;
         end else if (!m_init[k]) begin
            m_valid[k] = 0;
            mcyc[k]++;
            if (mcyc[k] == vmax) m_init[k] = 1;
         end else begin
            do_push = upd_valid && (mcnt[k] < 4);
            m_valid[k] = 0;
            case (pstate)
               2'd0: m_lat[k] = voice_index;
               2'd1: if (int'(m_lat[k]) < vmax) begin
                  s = {1'b0, mph[k][m_lat[k]]} + {1'b0, mdl[k][m_lat[k]]};
                  mph[k][m_lat[k]] = s[31:0];
                  m_phase[k] = s[31:22];
                  m_wrap[k] = s[32];
                  m_valid[k] = 1;
               end
               2'd2: if (mcnt[k] > 0) begin
                  e = mfifo[k][0];
                  for (int j = 0; j < 3; j++) mfifo[k][j] = mfifo[k][j+1];
                  mcnt[k]--;
                  if (int'(e[39:32]) < vmax) begin
                     mdl[k][e[39:32]] = e[31:0];
`ifdef DDS_PHASE_RESET_EN
                     if (e[40]) mph[k][e[39:32]] = '0;
`endif
                  end
               end
               default: ;
            endcase
            if (do_push) begin
               mfifo[k][mcnt[k]] = {upd_phase_rst, upd_voice, upd_delta};
               mcnt[k]++;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("a_phase_valid", a_valid, m_valid[0]);
         chk("a_phase", a_phase, m_phase[0]);
         chk("a_wrap", a_wrap, m_wrap[0]);
         chk("a_voice_index_next", a_vin, m_lat[0]);
         chk("a_init_done", a_init, m_init[0]);
         chk("a_upd_ready", a_ready, m_init[0] && mcnt[0] < 4);
         chk("b_phase_valid", b_valid, m_valid[1]);
         chk("b_phase", b_phase, m_phase[1]);
         chk("b_wrap", b_wrap, m_wrap[1]);
         chk("b_voice_index_next", b_vin, m_lat[1]);
         chk("b_init_done", b_init, m_init[1]);
         chk("b_upd_ready", b_ready, m_init[1] && mcnt[1] < 4);
      end
   end

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic [1:0] ps);
      pstate = ps;
      cycle();
   endtask

   task automatic read_accum(input logic [7:0] v);
      voice_index = v;
      step(2'd0);
      step(2'd1);
   endtask

   task automatic push(input logic [7:0] v, input logic [31:0] d, input logic r);
      upd_valid = 1'b1; upd_voice = v; upd_delta = d; upd_phase_rst = r;
      step(2'd3);
      upd_valid = 1'b0;
   endtask

   initial begin
      int n, na, nb, acc;
      rst = 1'b1; upd_valid = 1'b0; upd_phase_rst = 1'b0;
      upd_voice = '0; upd_delta = '0; voice_index = 8'd1; pstate = 2'd3;
      @(negedge clk);
      chk_en = 1'b1;
      cycle();
      chk("reset_phase", a_phase, 10'd0);
      chk("reset_ready", a_ready, 1'b0);
      chk("reset_init_done", a_init, 1'b0);

      // Sweep interrupted by reset, with ACCUM driven throughout (must be ignored).
      rst = 1'b0; pstate = 2'd1;
      repeat (100) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n = 0; na = 0; nb = 0;
      while ((na == 0 || nb == 0) && n < 300) begin
         n++;
         cycle();
         if (a_init && na == 0) na = n;
         if (b_init && nb == 0) nb = n;
      end
      chk("init_cycles_256", na, 256);
      chk("init_cycles_200", nb, 200);
      step(2'd3);

      read_accum(8'd5);
      chk("sweep_v5_valid", a_valid, 1'b1);
      chk("sweep_v5_phase", a_phase, 10'd0);
      step(2'd3);

      // Accumulate on voice 3.
      push(8'd3, 32'h0040_0000, 1'b0);
      read_accum(8'd3);
      step(2'd2);
      for (int i = 1; i <= 3; i++) begin
         read_accum(8'd3);
         chk("accum_phase", a_phase, 64'(i));
         step(2'd3);
      end

      // Wrap on voice 7.
      push(8'd7, 32'h8000_0000, 1'b0);
      step(2'd2);
      read_accum(8'd7);
      chk("wrap1_phase", a_phase, 10'h200);
      chk("wrap1_wrap", a_wrap, 1'b0);
      step(2'd3);
      read_accum(8'd7);
      chk("wrap2_phase", a_phase, 10'h000);
      chk("wrap2_wrap", a_wrap, 1'b1);
      step(2'd3);

      // Backpressure: six offers, only four fit.
      acc = 0;
      upd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         upd_voice = 8'(10 + i);
         upd_delta = 32'(i + 1) << 22;
         if (a_ready) acc++;
         step(2'd3);
      end
      upd_valid = 1'b0;
      chk("bp_accepted", acc, 4);
      chk("bp_ready_low", a_ready, 1'b0);
      repeat (4) step(2'd2);
      chk("bp_ready_back", a_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         read_accum(8'(10 + i));
         chk("bp_delta_applied", a_phase, 64'(i + 1));
         step(2'd3);
      end

      // Out of range for the 200-voice instance.
      read_accum(8'd250);
      chk("oor_b_no_strobe", b_valid, 1'b0);
      chk("oor_b_phase_hold", b_phase, 10'd4);
      chk("oor_a_strobe", a_valid, 1'b1);
      step(2'd3);
      push(8'd250, 32'h0040_0000, 1'b0);
      step(2'd2);
      for (int i = 0; i < 3; i++) push(8'(20 + i), 32'h0, 1'b0);
      chk("oor_b_entry_popped", b_ready, 1'b1);
      read_accum(8'd250);
      chk("oor_a_applied", a_phase, 10'd1);
      step(2'd3);
      repeat (3) step(2'd2);

      // Phase reset on voice 3 (phase currently 3 << 22).
      push(8'd3, 32'h0040_0000, 1'b1);
      step(2'd2);
      read_accum(8'd3);
`ifdef DDS_PHASE_RESET_EN
      chk("phase_rst_result", a_phase, 10'd1);
`else
      chk("phase_rst_result", a_phase, 10'd4);
`endif
      step(2'd3);
      step(2'd3);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
